// File: rtl/conv_window_sched_if.sv
// rtl/conv_window_sched_if.sv - control and result-handshake bundle between window sequencer and conv datapath
interface conv_window_sched_if #(
  parameter int AW = 5,
  parameter int FW = 4
);
  logic          conv_start;
  logic          load_xaddr;
  logic [AW-1:0] load_xaddr_val;
  logic          en_xaddr_incr;
  logic [FW-1:0] fmem_addr;
  logic          en_mult;
  logic          en_accum;
  logic          reset_accum;
  logic          m_valid_y;
  logic          m_ready_y;
  logic          conv_done;

  modport master (
    input  conv_start, m_ready_y,
    output load_xaddr, load_xaddr_val, en_xaddr_incr, fmem_addr,
           en_mult, en_accum, reset_accum, m_valid_y, conv_done
  );

  modport slave (
    output conv_start, m_ready_y,
    input  load_xaddr, load_xaddr_val, en_xaddr_incr, fmem_addr,
           en_mult, en_accum, reset_accum, m_valid_y, conv_done
  );
endinterface

// File: rtl/conv_window_sched.sv
// rtl/conv_window_sched.sv - per-window sequencer for the 1-D convolution datapath
// One LOAD/MAC/DRAIN/OUT pass per output y[win]; conv_done pulses after the final handshake.
module conv_window_sched #(
  parameter int N  = 20,
  parameter int M  = 13,
  parameter int AW = 5,
  parameter int FW = 4
) (
  input  logic clk,
  input  logic reset,
  conv_window_sched_if.master bus
);
  localparam int W = N - M + 1;
  localparam logic [FW-1:0] F_LAST   = FW'(M - 1);
  localparam logic [AW-1:0] WIN_LAST = AW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MAC, S_DRAIN1, S_DRAIN2, S_OUT, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] win;
  logic [FW-1:0] faddr;
  logic [1:0]    issue_d;
  logic          issue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.conv_start) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_MAC;
      S_MAC:    if (faddr == F_LAST) state_nxt = S_DRAIN1;
      S_DRAIN1: state_nxt = S_DRAIN2;
      S_DRAIN2: state_nxt = S_OUT;
      S_OUT:    if (bus.m_ready_y) state_nxt = (win == WIN_LAST) ? S_DONE : S_LOAD;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // issue_d aligns MAC issue with the 1-cycle memory read and the multiplier register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win     <= '0;
      faddr   <= '0;
      issue_d <= '0;
    end else begin
      issue_d <= {issue_d[0], issue};
      case (state)
        S_LOAD: faddr <= '0;
        S_MAC:  if (faddr != F_LAST) faddr <= faddr + FW'(1);
        S_OUT:  if (bus.m_ready_y && win != WIN_LAST) win <= win + AW'(1);
        S_DONE: win <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    issue              = 1'b0;
    bus.load_xaddr     = 1'b0;
    bus.load_xaddr_val = '0;
    bus.en_xaddr_incr  = 1'b0;
    bus.reset_accum    = 1'b0;
    bus.m_valid_y      = 1'b0;
    bus.conv_done      = 1'b0;
    case (state)
      S_LOAD: begin
        bus.load_xaddr     = 1'b1;
        bus.load_xaddr_val = win;
        bus.reset_accum    = 1'b1;
      end
      S_MAC: begin
        issue             = 1'b1;
        bus.en_xaddr_incr = (faddr != F_LAST);
      end
      S_OUT:   bus.m_valid_y = 1'b1;
      S_DONE:  bus.conv_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.fmem_addr = faddr;
  assign bus.en_mult   = issue_d[0];
  assign bus.en_accum  = issue_d[1];
endmodule

// File: tb/tb_conv_window_sched.sv
// tb/tb_conv_window_sched.sv - self-checking bench for conv_window_sched with a timeline reference model
module tb_conv_window_sched;
  localparam int N = 20, M = 13, AW = 5, FW = 4, W = N - M + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  conv_window_sched_if #(.AW(AW), .FW(FW)) bus ();
  conv_window_sched #(.N(N), .M(M), .AW(AW), .FW(FW)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  // Environment datapath: x memory + address counter, f ROM, multiplier, accumulator
  int xm[N];
  int fm[M];
  logic [AW-1:0] xaddr;
  int xq, fq, mreg, acc;

  always @(posedge clk) begin
    if (bus.load_xaddr) xaddr <= bus.load_xaddr_val;
    else if (bus.en_xaddr_incr) xaddr <= xaddr + 1'b1;
    xq <= (int'(xaddr) < N) ? xm[xaddr] : 0;
    fq <= (int'(bus.fmem_addr) < M) ? fm[bus.fmem_addr] : 0;
    if (bus.en_mult) mreg <= xq * fq;
    if (bus.reset_accum) acc <= 0;
    else if (bus.en_accum) acc <= acc + mreg;
  end

  int checks = 0, errors = 0;
  int cyc = 0;
  // Reference timeline: mode 0 idle, 1 running window m_w at phase m_p (0 = load cycle), 2 done
  int m_mode = 0, m_w = 0, m_p = 0, m_fl = 0;
  int n_mult, n_acc, n_incr, done_cnt, done_cyc;
  int hs_cyc[$];
  int yq[$];

  typedef struct {
    int xa, xb, fa;
    int stall, glitch;
    int y0, y7;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_y(input int i);
    int s = 0;
    for (int k = 0; k < M; k++) s += xm[i + k] * fm[k];
    return s;
  endfunction

  task automatic check_outputs();
    logic e_lx, e_inc, e_mu, e_ac, e_ra, e_v, e_d;
    int e_val, e_fa;
    logic [15:0] ev, av;
    e_lx = 0; e_inc = 0; e_mu = 0; e_ac = 0; e_ra = 0; e_v = 0; e_d = 0;
    e_val = 0; e_fa = m_fl;
    if (m_mode == 1) begin
      if (m_p == 0) begin e_lx = 1; e_ra = 1; e_val = m_w; end
      if (m_p >= 1 && m_p <= M) begin e_fa = m_p - 1; e_inc = (m_p <= M - 1); end
      e_mu = (m_p >= 2 && m_p <= M + 1);
      e_ac = (m_p >= 3 && m_p <= M + 2);
      e_v  = (m_p >= M + 3);
    end else if (m_mode == 2) begin
      e_d = 1;
    end
    ev = {e_lx, AW'(e_val), e_inc, FW'(e_fa), e_mu, e_ac, e_ra, e_v, e_d};
    av = {bus.load_xaddr, bus.load_xaddr_val, bus.en_xaddr_incr, bus.fmem_addr,
          bus.en_mult, bus.en_accum, bus.reset_accum, bus.m_valid_y, bus.conv_done};
    check("outputs{lx,val,inc,faddr,mult,acc,racc,valid,done}", int'(av), int'(ev));
    if (e_v) check("y_value", acc, ref_y(m_w));
    n_mult += int'(bus.en_mult);
    n_acc  += int'(bus.en_accum);
    n_incr += int'(bus.en_xaddr_incr);
    if (bus.conv_done) begin done_cnt++; done_cyc = cyc; end
  endtask

  task automatic cycle(input logic start, input logic ready);
    bus.conv_start = start;
    bus.m_ready_y  = ready;
    case (m_mode)
      0: if (start) begin m_mode = 1; m_w = 0; m_p = 0; end
      1: begin
        if (m_p >= M + 3) begin
          if (ready) begin
            hs_cyc.push_back(cyc);
            yq.push_back(acc);
            check("en_mult_pulses", n_mult, M);
            check("en_accum_pulses", n_acc, M);
            check("en_xaddr_incr_pulses", n_incr, M - 1);
            n_mult = 0; n_acc = 0; n_incr = 0;
            if (m_w == W - 1) m_mode = 2;
            else begin m_w++; m_p = 0; end
          end
        end else begin
          if (m_p == M) m_fl = M - 1;
          m_p++;
        end
      end
      default: m_mode = 0;
    endcase
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    bus.conv_start = 1'b0;
    bus.m_ready_y  = 1'b0;
    m_mode = 0; m_w = 0; m_p = 0; m_fl = 0;
    n_mult = 0; n_acc = 0; n_incr = 0;
    #1;
    check_outputs();
    repeat (hold) begin
      @(negedge clk);
      cyc++;
      check_outputs();
    end
    rst_n = 1'b1;
  endtask

  task automatic load_mem(input int xa, input int xb, input int fa);
    for (int i = 0; i < N; i++) xm[i] = xa * i + xb;
    for (int k = 0; k < M; k++) fm[k] = fa;
  endtask

  task automatic run_job(input int stall, input int glitch, input bit rnd, input int abort_win);
    int st = 0;
    int n = 0;
    logic rdy, sta;
    hs_cyc.delete(); yq.delete();
    done_cnt = 0; n_mult = 0; n_acc = 0; n_incr = 0;
    cycle(1'b1, 1'b1);
    while (m_mode != 0 && n < 1000) begin
      if (abort_win >= 0 && m_mode == 1 && m_w == abort_win && m_p == 6) begin
        apply_reset(2);
        return;
      end
      if (m_mode == 1 && m_p == 0) st = 0;
      if (rnd) begin
        sta = ($urandom_range(0, 7) == 0);
        rdy = ($urandom_range(0, 2) != 0);
      end else begin
        sta = (m_mode == 1 && m_w == glitch && m_p == 4);
        rdy = !(m_mode == 1 && m_p >= M + 3 && st < stall);
        if (!rdy) st++;
      end
      cycle(sta, rdy);
      n++;
    end
    bus.conv_start = 1'b0;
    if (m_mode != 0) begin
      checks++; errors++;
      $display("FAIL job_timeout: model still busy after %0d cycles", n);
    end
    check("handshake_count", hs_cyc.size(), W);
    check("conv_done_count", done_cnt, 1);
    if (hs_cyc.size() == W) begin
      check("conv_done_after_last_hs", done_cyc, hs_cyc[W-1] + 1);
      if (stall == 0 && !rnd)
        for (int i = 1; i < W; i++) check("hs_spacing", hs_cyc[i] - hs_cyc[i-1], M + 4);
    end
  endtask

  initial begin
    tbl[0] = '{xa: 1, xb: 1, fa: 1, stall: 0, glitch: -1, y0: 91,  y7: 182};
    tbl[1] = '{xa: 1, xb: 1, fa: 2, stall: 5, glitch: 3,  y0: 182, y7: 364};
    tbl[2] = '{xa: 0, xb: 3, fa: 5, stall: 0, glitch: 3,  y0: 195, y7: 195};
    tbl[3] = '{xa: 2, xb: 0, fa: 1, stall: 2, glitch: -1, y0: 156, y7: 338};

    bus.conv_start = 1'b0;
    bus.m_ready_y  = 1'b0;
    @(negedge clk);
    apply_reset(3);
    repeat (2) cycle(1'b0, 1'b1);

    for (int t = 0; t < 4; t++) begin
      load_mem(tbl[t].xa, tbl[t].xb, tbl[t].fa);
      run_job(tbl[t].stall, tbl[t].glitch, 1'b0, -1);
      if (yq.size() == W) begin
        check("tbl_y0", yq[0], tbl[t].y0);
        check("tbl_y7", yq[W-1], tbl[t].y7);
      end
      repeat (3) cycle(1'b0, 1'b0);
    end

    // Reset in the middle of window 5, then a clean restart from window 0
    load_mem(1, 1, 1);
    run_job(0, -1, 1'b0, 5);
    repeat (2) cycle(1'b0, 1'b1);
    run_job(0, -1, 1'b0, -1);
    if (yq.size() == W) check("restart_y0", yq[0], 91);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) xm[i] = int'($urandom_range(0, 255));
      for (int k = 0; k < M; k++) fm[k] = int'($urandom_range(0, 255));
      repeat (int'($urandom_range(1, 4))) cycle(1'b0, 1'b0);
      run_job(0, -1, 1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
